// File: rtl/seq_unsigned_divider.sv
// ---------------------------------------------------------------------------
// seq_unsigned_divider
//
// Iterative unsigned divider: Q = N / D, R = N % D for WIDTH-bit operands.
// It uses a restoring shift-subtract recurrence that resolves one quotient
// bit per clock, so a normal divide takes WIDTH cycles.
//
// Handshake semantics (both channels):
//   A transfer happens on the rising clk edge where valid && ready are both
//   high. The producer holds valid and its payload until that edge. The
//   consumer may hold ready low for as long as it likes. The request channel
//   (in_valid/in_ready, N, D) is only sampled in IDLE. The response channel
//   (out_valid/out_ready, Q, R, div_by_zero) holds its payload stable while
//   out_valid is high and out_ready is low.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     request valid (N, D)
//   in_ready     divider can accept a request (registered)
//   N, D         dividend, divisor
//   out_valid    result valid (registered)
//   out_ready    consumer accepts the result
//   Q, R         quotient, remainder (registered)
//   div_by_zero  accepted divisor was zero (registered)
//   dbg_state    current FSM state: 0 IDLE, 1 RUN, 2 DONE
// ---------------------------------------------------------------------------
module seq_unsigned_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] N,
    input  logic [WIDTH-1:0] D,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             div_by_zero,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH-1:0] shreg;   // dividend bits shift out the top, quotient bits shift in the bottom
    logic [WIDTH-1:0] rem;     // partial remainder, always < d_reg

    // One recurrence step. The trial value is WIDTH+1 bits so divisors above
    // 2^(WIDTH-1) still compare correctly; when it fits, the difference is
    // below d_reg and therefore fits back into WIDTH bits.
    logic [WIDTH:0]   trial;
    logic             fits;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] shreg_next;

    always_comb begin
        trial      = {rem, shreg[WIDTH-1]};
        fits       = (trial >= {1'b0, d_reg});
        rem_next   = fits ? WIDTH'(trial - {1'b0, d_reg}) : trial[WIDTH-1:0];
        shreg_next = {shreg[WIDTH-2:0], fits};
    end

    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            Q           <= '0;
            R           <= '0;
            div_by_zero <= 1'b0;
            count       <= '0;
            d_reg       <= '0;
            shreg       <= '0;
            rem         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        d_reg    <= D;
                        shreg    <= N;
                        rem      <= '0;
                        in_ready <= 1'b0;
                        if (D != '0) begin
                            count <= CW'(WIDTH);
                            state <= RUN;
                        end else begin
                            // Result is known at once; out_valid follows one
                            // cycle later from DONE.
                            Q           <= '1;
                            R           <= N;
                            div_by_zero <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end

                RUN: begin
                    shreg <= shreg_next;
                    rem   <= rem_next;
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        Q           <= shreg_next;
                        R           <= rem_next;
                        div_by_zero <= 1'b0;
                        out_valid   <= 1'b1;
                        state       <= DONE;
                    end
                end

                DONE: begin
                    // The divide-by-zero path arrives with out_valid still low.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_unsigned_divider.sv
module tb_seq_unsigned_divider;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 32-bit instance
    logic        iv32, ir32, ov32, or32, z32;
    logic [31:0] n32, d32, q32, r32;
    logic [1:0]  st32;

    // 8-bit instance
    logic        iv8, ir8, ov8, or8, z8;
    logic [7:0]  n8, d8, q8, r8;
    logic [1:0]  st8;

    seq_unsigned_divider #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv32), .in_ready(ir32), .N(n32), .D(d32),
        .out_valid(ov32), .out_ready(or32), .Q(q32), .R(r32),
        .div_by_zero(z32), .dbg_state(st32)
    );

    seq_unsigned_divider #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv8), .in_ready(ir8), .N(n8), .D(d8),
        .out_valid(ov8), .out_ready(or8), .Q(q8), .R(r8),
        .div_by_zero(z8), .dbg_state(st8)
    );

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] exp_q[$];   // expected {Q, R} per request

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    // Issue one request and wait (bounded) for out_valid. lat counts clock
    // edges after the accepting edge until out_valid is seen.
    task automatic div32(input logic [31:0] n, input logic [31:0] d,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic z, output int lat);
        int guard = 0;
        while (!ir32 && guard < 300) begin
            @(posedge clk); #1; guard++;
        end
        @(negedge clk);
        iv32 = 1'b1; n32 = n; d32 = d;
        @(posedge clk); #1;
        iv32 = 1'b0; n32 = $urandom; d32 = $urandom;
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!ov32 && lat < 300);
        q = q32; r = r32; z = z32;
    endtask

    task automatic div8(input logic [7:0] n, input logic [7:0] d,
                        output logic [7:0] q, output logic [7:0] r,
                        output logic z, output int lat);
        int guard = 0;
        while (!ir8 && guard < 300) begin
            @(posedge clk); #1; guard++;
        end
        @(negedge clk);
        iv8 = 1'b1; n8 = n; d8 = d;
        @(posedge clk); #1;
        iv8 = 1'b0; n8 = 8'($urandom); d8 = 8'($urandom);
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!ov8 && lat < 300);
        q = q8; r = r8; z = z8;
    endtask

    // Directed vector with out_ready held high; also checks the response
    // handshake and in_ready returning in the following cycle.
    task automatic run32(input string tag, input logic [31:0] n, input logic [31:0] d,
                         input logic [31:0] eq, input logic [31:0] er,
                         input logic ez, input int elat);
        logic [31:0] q, r;
        logic        z;
        int          lat;
        exp_q.push_back({eq, er});
        div32(n, d, q, r, z, lat);
        check({tag, " lat"}, 64'(lat), 64'(elat));
        check({tag, " QR"}, {q, r}, exp_q.pop_front());
        check({tag, " dbz"}, 64'(z), 64'(ez));
        @(posedge clk); #1;
        check({tag, " ov_after_hs"}, 64'(ov32), 64'd0);
        check({tag, " ir_after_hs"}, 64'(ir32), 64'd1);
    endtask

    task automatic run8(input string tag, input logic [7:0] n, input logic [7:0] d,
                        input logic [7:0] eq, input logic [7:0] er,
                        input logic ez, input int elat);
        logic [7:0] q, r;
        logic       z;
        int         lat;
        exp_q.push_back({48'd0, eq, er});
        div8(n, d, q, r, z, lat);
        check({tag, " lat"}, 64'(lat), 64'(elat));
        check({tag, " QR"}, {48'd0, q, r}, exp_q.pop_front());
        check({tag, " dbz"}, 64'(z), 64'(ez));
        @(posedge clk); #1;
        check({tag, " ov_after_hs"}, 64'(ov8), 64'd0);
        check({tag, " ir_after_hs"}, 64'(ir8), 64'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " ir"},  64'(ir32), 64'd1);
        check({tag, " ov"},  64'(ov32), 64'd0);
        check({tag, " Q"},   64'(q32),  64'd0);
        check({tag, " R"},   64'(r32),  64'd0);
        check({tag, " dbz"}, 64'(z32),  64'd0);
        check({tag, " st"},  64'(st32), 64'd0);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [31:0] q, r, n, d;
        logic [7:0]  q_8, r_8, n_8, d_8;
        logic        z;
        int          lat;

        rst_n = 1'b0;
        iv32 = 1'b0; n32 = '0; d32 = '0; or32 = 1'b1;
        iv8  = 1'b0; n8  = '0; d8  = '0; or8  = 1'b1;
        #12;
        check_reset_vals("reset");
        check("reset ov8", 64'(ov8), 64'd0);
        check("reset ir8", 64'(ir8), 64'd1);
        @(negedge clk); rst_n = 1'b1;

        // Basic and boundary vectors, 32-bit
        run32("100/7",          32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 32);
        run32("max/1",          32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 32);
        run32("max/max",        32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 32);
        run32("max/8000_0001",  32'hFFFF_FFFF,  32'h8000_0001,  32'd1,          32'h7FFF_FFFE,  1'b0, 32);
        run32("5/0",            32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, 1);
        run32("3/10",           32'd3,          32'd10,         32'd0,          32'd3,          1'b0, 32);
        run32("0/9",            32'd0,          32'd9,          32'd0,          32'd0,          1'b0, 32);

        // Backpressure: out_ready low, extra requests during RUN and DONE
        or32 = 1'b0;
        @(negedge clk); iv32 = 1'b1; n32 = 32'd100; d32 = 32'd7;
        @(posedge clk); #1; iv32 = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk); iv32 = 1'b1; n32 = 32'd50; d32 = 32'd3;
        check("bp ir_in_run", 64'(ir32), 64'd0);
        @(posedge clk); #1; iv32 = 1'b0;
        lat = 0;
        while (!ov32 && lat < 300) begin
            @(posedge clk); #1; lat++;
        end
        check("bp ov_seen", 64'(ov32), 64'd1);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                iv32 = 1'b1; n32 = 32'd77; d32 = 32'd5;
            end
            @(posedge clk); #1;
            iv32 = 1'b0;
            check($sformatf("bp hold%0d ov", i), 64'(ov32), 64'd1);
            check($sformatf("bp hold%0d QR", i), {q32, r32}, {32'd14, 32'd2});
            check($sformatf("bp hold%0d ir", i), 64'(ir32), 64'd0);
        end
        @(negedge clk); or32 = 1'b1;
        @(posedge clk); #1;
        check("bp release ov", 64'(ov32), 64'd0);
        check("bp release ir", 64'(ir32), 64'd1);
        check("bp release QR kept", {q32, r32}, {32'd14, 32'd2});
        @(posedge clk); #1;
        check("bp no_extra st", 64'(st32), 64'd0);
        check("bp no_extra ov", 64'(ov32), 64'd0);

        // Reset during RUN
        @(negedge clk); iv32 = 1'b1; n32 = 32'd200; d32 = 32'd13;
        @(posedge clk); #1; iv32 = 1'b0;
        repeat (10) @(posedge clk);
        #2; rst_n = 1'b0;
        #1;
        check_reset_vals("midrun rst");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("midrun hold%0d ov", i), 64'(ov32), 64'd0);
        end
        @(negedge clk); rst_n = 1'b1;
        run32("200/13 after rst", 32'd200, 32'd13, 32'd15, 32'd5, 1'b0, 32);

        // 8-bit instance
        run8("w8 200/13",  8'd200, 8'd13,  8'd15,  8'd5,   1'b0, 8);
        run8("w8 255/16",  8'd255, 8'd16,  8'd15,  8'd15,  1'b0, 8);
        run8("w8 7/200",   8'd7,   8'd200, 8'd0,   8'd7,   1'b0, 8);
        run8("w8 200/0",   8'd200, 8'd0,   8'hFF,  8'hC8,  1'b1, 1);
        run8("w8 255/255", 8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 8);
        run8("w8 255/129", 8'd255, 8'd129, 8'd1,   8'd126, 1'b0, 8);

        // Random pairs: Q*D+R == N and R < D (or the divide-by-zero result)
        for (int i = 0; i < 1000; i++) begin
            n = $urandom;
            d = $urandom >> $urandom_range(0, 31);
            div32(n, d, q, r, z, lat);
            if (d == 32'd0) begin
                check("rnd32 dbz QR", {q, r}, {32'hFFFF_FFFF, n});
                check("rnd32 dbz flag", 64'(z), 64'd1);
            end else begin
                check($sformatf("rnd32 %0d/%0d identity", n, d),
                      64'(q) * 64'(d) + 64'(r), 64'(n));
                check($sformatf("rnd32 %0d/%0d r<d", n, d), 64'(r < d), 64'd1);
            end
            @(posedge clk); #1;
        end
        for (int i = 0; i < 1000; i++) begin
            n_8 = 8'($urandom);
            d_8 = 8'($urandom) >> $urandom_range(0, 7);
            div8(n_8, d_8, q_8, r_8, z, lat);
            if (d_8 == 8'd0) begin
                check("rnd8 dbz QR", {48'd0, q_8, r_8}, {48'd0, 8'hFF, n_8});
                check("rnd8 dbz flag", 64'(z), 64'd1);
            end else begin
                check($sformatf("rnd8 %0d/%0d identity", n_8, d_8),
                      64'(q_8) * 64'(d_8) + 64'(r_8), 64'(n_8));
                check($sformatf("rnd8 %0d/%0d r<d", n_8, d_8), 64'(r_8 < d_8), 64'd1);
            end
            @(posedge clk); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seq_unsigned_divider.md
# seq_unsigned_divider

Parametrised, iterative unsigned integer divider producing quotient and remainder of a WIDTH-bit dividend by a WIDTH-bit divisor. It uses the restoring shift-subtract recurrence and resolves one quotient bit per clock. Each operand pair enters through a valid/ready request channel and each result leaves through a valid/ready response channel. It sits in the datapath wherever a multi-cycle divide is acceptable, and replaces chains of single-step remainder stages.

## Interface
- WIDTH, 32, operand/result width in bits; legal range 2..64.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset; one clock domain only.
- in_valid  input  1  request: N and D are valid.
- in_ready  output  1  divider can accept a request.
- N  input  WIDTH  dividend.
- D  input  WIDTH  divisor.
- out_valid  output  1  Q, R and div_by_zero are valid.
- out_ready  input  1  consumer accepts the result.
- Q  output  WIDTH  quotient.
- R  output  WIDTH  remainder.
- div_by_zero  output  1  set when the accepted D was 0.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values (asynchronous, immediate on rst_n low):
  - state=IDLE, in_ready=1, out_valid=0.
  - Q=0, R=0, div_by_zero=0.
  - Iteration counter=0.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready, latch D, load the quotient shift register with N, and clear the partial remainder.
  - If D≠0: set counter=WIDTH and go to RUN.
  - If D==0: set Q=all ones, R=N, div_by_zero=1, and go to DONE.
- RUN (in_ready=0), once per cycle:
  - Form T = {partial remainder, MSB of the shift register}, WIDTH+1 bits wide.
  - If T ≥ {0,D}: partial remainder = T−D and shift 1 into the LSB of the quotient shift register.
  - Otherwise: partial remainder = T[WIDTH-1:0] and shift 0 in.
  - The shift register shifts left by one each iteration.
  - Decrement the counter. After the iteration where the counter reaches 0, drive Q=shift register, R=partial remainder, div_by_zero=0, and go to DONE.
- DONE:
  - out_valid=1 and in_ready=0.
  - Q, R and div_by_zero are held stable while out_ready=0.
  - On out_ready, go to IDLE with out_valid=0. Q/R/div_by_zero retain their values until the next result.
- in_valid is ignored outside IDLE. N and D may change freely after the accepting edge.
- Arithmetic:
  - The comparison and subtraction are WIDTH+1 bits wide to avoid overflow when D > 2^(WIDTH-1).
  - The invariant R < D holds for every D≠0.
  - Q*D+R == N holds exactly.
- Reset mid-operation (RUN or DONE) aborts. The in-flight request is lost and no result is produced.

## Timing
- Request handshake completes on the rising edge where in_valid && in_ready.
- Normal latency: out_valid rises WIDTH cycles after the accepting edge. It is registered, with no combinational input-to-output path.
- Divide-by-zero latency: out_valid rises 1 cycle after the accepting edge.
- Response handshake completes on the edge where out_valid && out_ready. in_ready rises in the following cycle.
- No overlap: the next request can be accepted no earlier than the cycle after the response handshake.
- Minimum initiation interval: WIDTH+2 cycles with out_ready held high.
- in_ready, out_valid and all result outputs are driven directly from flops.

## Test plan
- WIDTH=32, N=100, D=7, out_ready=1 -> out_valid exactly 32 cycles after accept; Q=14, R=2, div_by_zero=0; in_ready returns 1 the cycle after the response handshake.
- WIDTH=32, N=0xFFFFFFFF with D=1, then D=0xFFFFFFFF, then D=0x80000001 -> (Q=0xFFFFFFFF, R=0), (Q=1, R=0), (Q=1, R=0x7FFFFFFE); the last case exercises the WIDTH+1 compare.
- WIDTH=32, N=5, D=0 -> out_valid 1 cycle after accept; Q=0xFFFFFFFF, R=5, div_by_zero=1. Then N=3, D=10 -> Q=0, R=3, div_by_zero cleared.
- Backpressure: hold out_ready=0 for 5 cycles in DONE and pulse in_valid with new operands during RUN/DONE -> results stable, in_ready=0, extra requests ignored; result released on the first out_ready cycle.
- Reset mid-RUN: assert rst_n=0 at iteration 10 of 200/13 -> all outputs at reset values immediately, with no out_valid pulse. A fresh request afterwards completes correctly.
- WIDTH=8, N=200, D=13 -> Q=15, R=5 after 8 cycles. Plus 1000 random pairs per WIDTH∈{8,32}, checked against Q*D+R==N and R<D.
